store_buffer: RTL and testbench
===============================

# store_buffer

Write buffer between the MEM-stage control of the pipelined MIPS core and the single-port data memory. Stores from the MEM stage are queued in a small FIFO and retired into data memory, one per cycle, on cycles the memory port is not needed by a load. Loads get priority on the memory port. A load whose address matches a buffered store receives the youngest matching buffered data instead of the stale memory word.

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥2
- AW, 32, address width (word address, driven straight onto data memory `addr`)
- DW, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- st_valid  in  1  MEM stage presents a store this cycle
- st_addr  in  AW  store word address
- st_data  in  DW  store data
- st_ready  out  1  store accepted this cycle (= !full)
- stall  out  1  st_valid && !st_ready; hazard unit freezes the pipeline
- ld_valid  in  1  MEM stage presents a load this cycle
- ld_addr  in  AW  load word address
- ld_hit  out  1  ld_valid and a valid entry matches ld_addr
- ld_data  out  DW  ld_hit ? youngest matching entry data : mem_rd
- mem_addr  out  AW  to data memory `addr`
- mem_wd  out  DW  to data memory `WD`
- mem_we  out  1  to data memory `WE`
- mem_rd  in  DW  from data memory `RD` (combinational read)
- count  out  $clog2(DEPTH+1)  occupied entries
- empty  out  1  count == 0

## Operation
- Storage: circular FIFO, arrays addr/data/valid, head (oldest) and tail pointers, both $clog2(DEPTH) bits, wrapping naturally.
- Push: st_valid && st_ready at a rising edge writes {st_addr, st_data} at tail, sets valid, tail+1, count+1.
- Port arbitration (combinational):
  - ld_valid=1: mem_addr=ld_addr, mem_we=0, no drain.
  - else, when !empty: mem_addr=head addr, mem_wd=head data, mem_we=1; the memory captures the write on the same edge at which head+1 and count−1 take effect.
  - else: mem_we=0, mem_addr=0, mem_wd=0.
- Forwarding: ld_addr is compared against all valid entries. Youngest match (closest to tail) wins. Match logic is combinational.
- A store being pushed in the same cycle is not visible to a same-cycle load.
- Simultaneous push and drain: count is unchanged, both pointers advance.
- Full (count==DEPTH): st_ready=0. No pass-through of a store into a freed slot in the same cycle.
- No deadlock: a stalled store implies ld_valid=0, so the buffer drains.

## Timing
- Reset (async, immediate), all outputs:
  - count=0, empty=1, st_ready=1, stall=0.
  - ld_hit=0, mem_we=0.
  - All valid bits 0, pointers 0.
  - ld_data follows mem_rd.
- Store latency:
  - Accepted at edge N.
  - Earliest memory write at edge N+1, if ld_valid=0 during cycle N→N+1.
  - Each load cycle delays the write by one cycle.
- Drain rate: at most one entry per cycle, in FIFO order.
- Load data: same cycle (combinational), from either the buffer or mem_rd.
- Reset mid-operation: buffered stores are discarded and never written. Data memory is cleared by its own reset.

## Structure
- Shared package: DEPTH, AW, DW defaults and the sb_entry_t struct {valid, addr, data}.
- Sub-module `sb_match`:
  - Inputs: entry array, head index, ld_addr.
  - Outputs: hit and youngest-match index. This is a priority search rotated by head.
- Top level: FIFO pointers, count, arbitration mux.

## Test plan
1. Reset → count=0, empty=1, st_ready=1, mem_we=0, ld_hit=0. Then assert rst low while entries are held → all of these return to reset values immediately and no write is seen afterwards.
2. Single store addr 5 data 0xDEADBEEF, no loads → next cycle mem_we=1, mem_addr=5, mem_wd=0xDEADBEEF; after that edge count=0 and memory word 5 reads 0xDEADBEEF.
3. Store addr 7 = 0x12345678, then ld_valid addr 7 on the next cycle → ld_hit=1, ld_data=0x12345678, mem_we=0; the entry drains on the first cycle with no load.
4. Stores addr 3 = 0x11 then addr 3 = 0x22 with ld_valid held at addr 3 → ld_data=0x22. Load addr 4 → ld_hit=0, ld_data=mem_rd.
5. Four stores with ld_valid held high → count=4, st_ready=0; a fifth st_valid gives stall=1. Drop ld_valid → four consecutive mem_we cycles in push order, and the fifth store is accepted once count<4.
6. Push and drain in the same cycle at count=2 → count stays 2 and pointers wrap correctly past index DEPTH−1.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared sizing defaults and the buffer entry layout for the MEM-stage store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Load-address search over the buffer: finds the youngest valid entry whose address matches.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  sb_entry_t        entries_i [DEPTH],
  input  logic [PW-1:0]    head_i,
  input  logic [SB_AW-1:0] ld_addr_i,
  output logic             hit_o,
  output logic [PW-1:0]    idx_o
);

  // Walk from oldest (head) towards tail; a later match overwrites, so the youngest wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      if (entries_i[head_i + PW'(k)].valid &&
          entries_i[head_i + PW'(k)].addr == ld_addr_i) begin
        hit_o = 1'b1;
        idx_o = head_i + PW'(k);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM stage and single-port data memory: FIFO of stores drained
// on load-free cycles, with youngest-match forwarding to same-cycle loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  output logic          stall,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic [CW-1:0] count,
  output logic          empty
);

  // Handshake: a store is accepted on a rising edge where st_valid && st_ready;
  // st_ready depends only on registered occupancy, never on st_valid or ld_valid.

  sb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, push, drain;
  logic          match_hit;
  logic [PW-1:0] match_idx;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign st_ready = !full;
  assign stall    = st_valid && !st_ready;
  assign push     = st_valid && st_ready;
  // Loads own the memory port; the buffer drains only on load-free cycles.
  assign drain    = !ld_valid && !empty;

  always_comb begin
    head_d  = drain ? head_q + PW'(1) : head_q;
    tail_d  = push  ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // push and drain never hit the same slot: that needs head==tail, i.e. empty or full.
      if (push) begin
        ent_q[tail_q].valid <= 1'b1;
        ent_q[tail_q].addr  <= st_addr;
        ent_q[tail_q].data  <= st_data;
      end
      if (drain) ent_q[head_q].valid <= 1'b0;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries_i (ent_q),
    .head_i    (head_q),
    .ld_addr_i (ld_addr),
    .hit_o     (match_hit),
    .idx_o     (match_idx)
  );

  assign ld_hit  = ld_valid && match_hit;
  assign ld_data = ld_hit ? ent_q[match_idx].data : mem_rd;

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    if (ld_valid) begin
      mem_addr = ld_addr;
    end else if (!empty) begin
      mem_addr = ent_q[head_q].addr;
      mem_wd   = ent_q[head_q].data;
      mem_we   = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: small data memory model, write-order scoreboard,
// hand-computed expectations for reset, drain, forwarding, full/stall and wrap cases.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, ld_valid;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        st_ready, stall, ld_hit, mem_we, empty;
  logic [31:0] ld_data, mem_addr, mem_wd, mem_rd;
  logic [2:0]  count;

  logic [31:0] dmem [256];
  logic [63:0] exp_q [$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .stall    (stall),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .count    (count),
    .empty    (empty)
  );

  // Data memory: combinational read, write on rising edge, cleared by its own reset.
  assign mem_rd = dmem[mem_addr[7:0]];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    end else if (mem_we) begin
      dmem[mem_addr[7:0]] <= mem_wd;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every memory write must be the oldest accepted, not-yet-written store.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (exp_q.size() == 0) check_eq("unexp_wr", 64'(exp_q.size()), 64'd1);
      else check_eq("wr_order", {mem_addr, mem_wd}, exp_q.pop_front());
    end
    if (rst && st_valid && st_ready) exp_q.push_back({st_addr, st_data});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic set_ld(input logic v, input logic [31:0] a);
    ld_valid = v;
    ld_addr  = a;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    set_st(1'b0, '0, '0);
    set_ld(1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_count",    64'(count),    64'd0);
    check_eq("rst_empty",    64'(empty),    64'd1);
    check_eq("rst_st_ready", 64'(st_ready), 64'd1);
    check_eq("rst_stall",    64'(stall),    64'd0);
    check_eq("rst_mem_we",   64'(mem_we),   64'd0);
    check_eq("rst_ld_hit",   64'(ld_hit),   64'd0);
    cyc();
    rst = 1'b1;

    // Reset mid-operation: two stores held by a load, then discarded.
    set_ld(1'b1, 32'h40);
    set_st(1'b1, 32'h30, 32'h77);
    cyc();
    set_st(1'b1, 32'h31, 32'h78);
    cyc();
    set_st(1'b0, '0, '0);
    @(negedge clk);
    check_eq("held_count", 64'(count), 64'd2);
    cyc();
    rst = 1'b0;
    exp_q.delete();
    set_ld(1'b0, '0);
    #1;
    check_eq("mid_rst_count",  64'(count),    64'd0);
    check_eq("mid_rst_empty",  64'(empty),    64'd1);
    check_eq("mid_rst_ready",  64'(st_ready), 64'd1);
    check_eq("mid_rst_mem_we", 64'(mem_we),   64'd0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_wr", 64'(mem_we), 64'd0);
    end
    cyc();
    set_ld(1'b1, 32'h30);
    @(negedge clk);
    check_eq("post_rst_mem30", 64'(ld_data), 64'd0);
    cyc();
    set_ld(1'b0, '0);

    // Single store drains on the next cycle.
    set_st(1'b1, 32'd5, 32'hDEADBEEF);
    cyc();
    set_st(1'b0, '0, '0);
    @(negedge clk);
    check_eq("t2_mem_we",   64'(mem_we),   64'd1);
    check_eq("t2_mem_addr", 64'(mem_addr), 64'd5);
    check_eq("t2_mem_wd",   64'(mem_wd),   64'hDEADBEEF);
    cyc();
    set_ld(1'b1, 32'd5);
    @(negedge clk);
    check_eq("t2_count",   64'(count),   64'd0);
    check_eq("t2_ld_hit",  64'(ld_hit),  64'd0);
    check_eq("t2_mem5",    64'(ld_data), 64'hDEADBEEF);
    cyc();
    set_ld(1'b0, '0);

    // Forwarding to a load the cycle after the store; drain once the load goes away.
    set_st(1'b1, 32'd7, 32'h12345678);
    cyc();
    set_st(1'b0, '0, '0);
    set_ld(1'b1, 32'd7);
    @(negedge clk);
    check_eq("t3_ld_hit",  64'(ld_hit),  64'd1);
    check_eq("t3_ld_data", 64'(ld_data), 64'h12345678);
    check_eq("t3_mem_we",  64'(mem_we),  64'd0);
    check_eq("t3_count",   64'(count),   64'd1);
    cyc();
    set_ld(1'b0, '0);
    @(negedge clk);
    check_eq("t3_drain_we",   64'(mem_we),   64'd1);
    check_eq("t3_drain_addr", 64'(mem_addr), 64'd7);
    cyc();
    @(negedge clk);
    check_eq("t3_count_end", 64'(count), 64'd0);

    // Two stores to one address: youngest wins; same-cycle push not visible.
    set_ld(1'b1, 32'd3);
    set_st(1'b1, 32'd3, 32'h11);
    cyc();
    set_st(1'b1, 32'd3, 32'h22);
    @(negedge clk);
    check_eq("t4_old_only", 64'(ld_data), 64'h11);
    cyc();
    set_st(1'b0, '0, '0);
    @(negedge clk);
    check_eq("t4_youngest", 64'(ld_data), 64'h22);
    check_eq("t4_hit",      64'(ld_hit),  64'd1);
    check_eq("t4_count",    64'(count),   64'd2);
    cyc();
    set_ld(1'b1, 32'd5);
    @(negedge clk);
    check_eq("t4_miss_hit",  64'(ld_hit),  64'd0);
    check_eq("t4_miss_data", 64'(ld_data), 64'hDEADBEEF);
    cyc();
    set_ld(1'b0, '0);
    cyc();
    cyc();
    set_ld(1'b1, 32'd3);
    @(negedge clk);
    check_eq("t4_count_end", 64'(count),   64'd0);
    check_eq("t4_mem3",      64'(ld_data), 64'h22);
    cyc();

    // Fill under a held load, stall the fifth store, then drain back to back.
    set_ld(1'b1, 32'h40);
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, 32'h10 + 32'(i), 32'hA0 + 32'(i));
      cyc();
    end
    set_st(1'b1, 32'h20, 32'hB5);
    @(negedge clk);
    check_eq("t5_count_full", 64'(count),    64'd4);
    check_eq("t5_not_ready",  64'(st_ready), 64'd0);
    check_eq("t5_stall",      64'(stall),    64'd1);
    check_eq("t5_no_we",      64'(mem_we),   64'd0);
    cyc();
    set_ld(1'b0, '0);
    @(negedge clk);
    check_eq("t5_first_we",   64'(mem_we),   64'd1);
    check_eq("t5_first_addr", 64'(mem_addr), 64'h10);
    check_eq("t5_stall_hold", 64'(stall),    64'd1);
    cyc();
    @(negedge clk);
    check_eq("t5_ready_again", 64'(st_ready), 64'd1);
    check_eq("t5_stall_clear", 64'(stall),    64'd0);
    check_eq("t5_second_we",   64'(mem_we),   64'd1);
    cyc();
    set_st(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t5_drain_run", 64'(mem_we), 64'd1);
      cyc();
    end
    @(negedge clk);
    check_eq("t5_count_end", 64'(count),  64'd0);
    check_eq("t5_idle_we",   64'(mem_we), 64'd0);

    // Simultaneous push and drain at count 2, wrapping pointers past the last slot.
    set_ld(1'b1, 32'h40);
    set_st(1'b1, 32'h50, 32'hC0);
    cyc();
    set_st(1'b1, 32'h51, 32'hC1);
    cyc();
    set_ld(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, 32'h52 + 32'(i), 32'hC2 + 32'(i));
      @(negedge clk);
      check_eq("t6_count_pd", 64'(count), 64'd2);
      cyc();
    end
    set_st(1'b0, '0, '0);
    set_ld(1'b1, 32'h53);
    @(negedge clk);
    check_eq("t6_count",     64'(count),   64'd2);
    check_eq("t6_wrap_hit",  64'(ld_hit),  64'd1);
    check_eq("t6_wrap_data", 64'(ld_data), 64'hC3);
    cyc();
    set_ld(1'b0, '0);
    for (int i = 0; i < 10 && !empty; i++) cyc();
    @(negedge clk);
    check_eq("t6_empty",  64'(empty),        64'd1);
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
